instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Instruction fetch/issue sequencer. It is the initiator side of the opcode interface consumed by the CPU controller.
- It fetches 8-bit instruction words from program memory over a req/ack handshake. Each word is split into a 4-bit opcode and a 4-bit operand.
- Each opcode is presented to the controller for exactly one cycle; at all other times the opcode output is NOP (4'b0000).
- The sequencer runs from address 0 until it issues the HALT opcode.

Parameters:
- ADDR_W, 4, program-memory address width; PC wraps modulo 2^ADDR_W.
- HALT_OP, 4'b1111, opcode that terminates the run after being issued.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin execution from address 0; honoured only in IDLE or HALTED.
- mem_req  output  1  fetch request to program memory.
- mem_addr  output  ADDR_W  fetch address, equals pc while mem_req=1.
- mem_ack  input  1  memory returns mem_rdata valid in this cycle.
- mem_rdata  input  8  instruction word: [7:4] opcode, [3:0] operand.
- opcode  output  4  opcode to controller; 4'b0000 except in ISSUE.
- operand  output  4  operand accompanying opcode; 4'b0000 except in ISSUE.
- issue_valid  output  1  high exactly in ISSUE cycles.
- pc  output  ADDR_W  current program counter.
- busy  output  1  high in FETCH or ISSUE.
- halted  output  1  high in HALTED.

Behaviour:
- Reset: synchronous; rst_n low at a rising edge forces the following:
  - state = IDLE; pc = 0; instruction register = 8'h00.
  - mem_req = 0, opcode = 0, operand = 0, issue_valid = 0, busy = 0, halted = 0.
  - Reset mid-fetch or mid-issue aborts the run; mem_req drops after that edge.
- All outputs are registered or decoded purely from state and registers. There are no combinational paths from mem_ack or mem_rdata to any output.
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE:
  - start=1 → FETCH with pc=0.
  - mem_ack is ignored.
- FETCH:
  - mem_req=1 and mem_addr=pc, both held stable until mem_ack.
  - mem_ack=1 → capture mem_rdata into the IR and go to ISSUE.
  - Any number of wait cycles is allowed (no timeout). Zero-wait ack is legal: ack may arrive in the first cycle mem_req is high.
- ISSUE (always exactly one cycle):
  - issue_valid=1, opcode=IR[7:4], operand=IR[3:0], mem_req=0.
  - If IR[7:4]==HALT_OP → HALTED; pc is unchanged.
  - Otherwise pc ← pc+1 (mod 2^ADDR_W, so pc=2^ADDR_W-1 wraps to 0) → FETCH.
- HALTED:
  - halted=1, mem_req=0.
  - start=1 → FETCH with pc=0, halted drops.
- start is ignored in FETCH and ISSUE. mem_ack outside FETCH is ignored.
- Latency:
  - start sampled at edge N → mem_req high from cycle N+1.
  - Ack sampled at edge M → issue_valid high in cycle M+1.
  - Next mem_req begins at cycle M+2.
  - Throughput with zero-wait memory: one instruction per 2 cycles.
- Unknown or reserved opcodes are issued unchanged; decoding is the controller's job. Opcode 0000 is issued as a NOP-valid cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 and mem_ack=1 → all outputs 0 and pc=0. Release with start=0 → stays IDLE, mem_req=0.
- Zero-wait program: memory {0x15, 0x2A, 0x30, 0xF0}, mem_ack tied to mem_req, pulse start →
  - issue_valid pulses on 4 cycles 2 apart.
  - opcode/operand sequence: 1/5, 2/A, 3/0, F/0.
  - halted=1 with pc=3; opcode=0 in all non-issue cycles.
- Wait states: ack delayed 3 cycles per fetch → mem_addr stable for 4 cycles per fetch, same issue sequence, 5 cycles per instruction.
- Wrap-around: all 16 words = 0x10 → after address 15 the fetch address returns to 0; no halt; issue_valid continues.
- Ignored controls:
  - start pulsed during FETCH and ISSUE, and mem_ack pulsed in IDLE/HALTED → no state, pc or IR change.
  - start in HALTED → refetch from address 0.
- Reset mid-run: assert rst_n=0 during a FETCH with ack pending → next cycle mem_req=0, pc=0, IDLE. A later start restarts at address 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 8-bit instruction words from program memory over a
// req/ack handshake and issues each opcode/operand pair to the CPU controller
// for exactly one cycle. The run starts at address 0 and stops after a HALT
// opcode has been issued.
module instr_sequencer #(
  parameter int          ADDR_W  = 4,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic              issue_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state;
  logic [7:0]        ir;
  logic [ADDR_W-1:0] pc_q;

  // Sequencer FSM: state, program counter and instruction register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_q  <= '0;
      ir    <= 8'h00;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state <= FETCH;
            pc_q  <= '0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (ir[7:4] == HALT_OP) begin
            state <= HALTED;
          end else begin
            pc_q  <= pc_q + ADDR_W'(1);
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded only from registered state, so memory inputs never reach an output combinationally.
  always_comb begin
    mem_req     = (state == FETCH);
    issue_valid = (state == ISSUE);
    busy        = (state == FETCH) || (state == ISSUE);
    halted      = (state == HALTED);
    opcode      = (state == ISSUE) ? ir[7:4] : 4'b0000;
    operand     = (state == ISSUE) ? ir[3:0] : 4'b0000;
    mem_addr    = pc_q;
    pc          = pc_q;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench for instr_sequencer. Directed programs
// push their expected issue sequence into a queue; a monitor pops and compares
// on every issue_valid cycle. A memory responder models wait states.
module tb_instr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mem_req;
  logic [3:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       issue_valid;
  logic [3:0] pc;
  logic       busy;
  logic       halted;

  typedef struct {
    logic [3:0] op;
    logic [3:0] opr;
    logic [3:0] pc;
    int         gap;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] prog[16];
  int         checks = 0;
  int         failures = 0;
  int         ack_delay = 0;
  bit         force_ack = 0;
  bit         mon_en = 0;
  int         cycle = 0;
  int         last_issue = 0;
  int         req_run = 0;
  int         last_req_len = 0;

  instr_sequencer #(.ADDR_W(4), .HALT_OP(4'b1111)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .opcode(opcode),
    .operand(operand),
    .issue_valid(issue_valid),
    .pc(pc),
    .busy(busy),
    .halted(halted)
  );

  assign mem_rdata = prog[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic loadHaltProgram();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'h15;
    prog[1] = 8'h2A;
    prog[2] = 8'h30;
    prog[3] = 8'hF0;
  endtask

  task automatic pushHaltExpect(input int gap);
    sb.push_back('{op: 4'h1, opr: 4'h5, pc: 4'd0, gap: -1});
    sb.push_back('{op: 4'h2, opr: 4'hA, pc: 4'd1, gap: gap});
    sb.push_back('{op: 4'h3, opr: 4'h0, pc: 4'd2, gap: gap});
    sb.push_back('{op: 4'hF, opr: 4'h0, pc: 4'd3, gap: gap});
  endtask

  task automatic waitHalted(input int limit);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    checkOutput("halt_timeout", {31'd0, halted}, 32'd1);
  endtask

  task automatic waitQueueEmpty(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    checkOutput("queue_drain", sb.size(), 0);
  endtask

  // Memory responder: acks after ack_delay wait cycles, or forces ack when asked.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        mem_ack = 1'b1;
        wcnt = 0;
      end else if (mem_req === 1'b1) begin
        if (wcnt >= ack_delay) begin
          mem_ack = 1'b1;
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: scoreboard pops on every issue, NOP checks otherwise, fetch address tracking.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (mon_en) begin
        if (issue_valid === 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_issue actual=%0h/%0h expected=none at cycle %0d", opcode, operand, cycle);
          end else begin
            e = sb.pop_front();
            checkOutput("issue_opcode", {28'd0, opcode}, {28'd0, e.op});
            checkOutput("issue_operand", {28'd0, operand}, {28'd0, e.opr});
            checkOutput("issue_pc", {28'd0, pc}, {28'd0, e.pc});
            if (e.gap >= 0) checkOutput("issue_gap", cycle - last_issue, e.gap);
          end
          last_issue = cycle;
        end else begin
          checkOutput("nop_outputs", {24'd0, opcode, operand}, 32'd0);
        end
        if (mem_req === 1'b1) begin
          checkOutput("mem_addr_eq_pc", {28'd0, mem_addr}, {28'd0, pc});
          req_run++;
        end else if (req_run != 0) begin
          last_req_len = req_run;
          req_run = 0;
        end
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    rst_n = 1'b0;
    start = 1'b1;
    force_ack = 1'b1;
    repeat (3) tick();
    checkOutput("reset_outputs",
                {20'd0, mem_req, issue_valid, opcode, operand, busy, halted},
                32'd0);
    checkOutput("reset_pc", {28'd0, pc}, 32'd0);

    rst_n = 1'b1;
    start = 1'b0;
    force_ack = 1'b0;
    tick();
    tick();
    checkOutput("idle_after_reset", {29'd0, mem_req, busy, halted}, 32'd0);
    mon_en = 1'b1;

    $display("[TB] zero-wait program");
    loadHaltProgram();
    ack_delay = 0;
    pushHaltExpect(2);
    applyStimulus();
    checkOutput("start_latency", {27'd0, mem_req, mem_addr}, {27'd0, 1'b1, 4'd0});
    waitHalted(100);
    checkOutput("halt_pc", {28'd0, pc}, 32'd3);
    checkOutput("halt_flags", {30'd0, busy, halted}, 32'd1);
    checkOutput("zero_wait_drained", sb.size(), 0);

    $display("[TB] wait-state program restarted from HALTED");
    ack_delay = 3;
    pushHaltExpect(5);
    applyStimulus();
    checkOutput("restart_from_halt", {27'd0, mem_req, mem_addr}, {27'd0, 1'b1, 4'd0});
    waitHalted(200);
    checkOutput("wait_halt_pc", {28'd0, pc}, 32'd3);
    checkOutput("wait_req_len", last_req_len, 4);
    checkOutput("wait_drained", sb.size(), 0);

    $display("[TB] start held through FETCH and ISSUE");
    ack_delay = 0;
    pushHaltExpect(2);
    start = 1'b1;
    for (int n = 0; n < 100 && halted !== 1'b0; n++) tick();
    for (int n = 0; n < 100; n++) begin
      tick();
      if (issue_valid === 1'b1 && opcode == 4'hF) begin
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    waitHalted(20);
    checkOutput("held_start_drained", sb.size(), 0);
    checkOutput("held_start_pc", {28'd0, pc}, 32'd3);

    $display("[TB] mem_ack in HALTED");
    force_ack = 1'b1;
    tick();
    tick();
    force_ack = 1'b0;
    tick();
    checkOutput("ack_in_halted", {27'd0, halted, pc}, {27'd0, 1'b1, 4'd3});

    $display("[TB] wrap-around program");
    for (int i = 0; i < 16; i++) prog[i] = 8'h10;
    for (int i = 0; i < 18; i++)
      sb.push_back('{op: 4'h1, opr: 4'h0, pc: 4'(i), gap: (i == 0) ? -1 : 2});
    applyStimulus();
    waitQueueEmpty(100);
    checkOutput("wrap_running", {30'd0, busy, halted}, 32'd2);

    $display("[TB] reset during FETCH with ack pending");
    tick();
    checkOutput("fetch_before_reset", {30'd0, mem_req, mem_ack}, 32'd3);
    rst_n = 1'b0;
    tick();
    checkOutput("reset_mid_fetch",
                {24'd0, mem_req, issue_valid, busy, halted, pc},
                32'd0);
    rst_n = 1'b1;
    force_ack = 1'b1;
    tick();
    tick();
    force_ack = 1'b0;
    tick();
    checkOutput("ack_in_idle", {29'd0, mem_req, busy, halted}, 32'd0);

    loadHaltProgram();
    pushHaltExpect(2);
    applyStimulus();
    checkOutput("restart_after_reset", {27'd0, mem_req, mem_addr}, {27'd0, 1'b1, 4'd0});
    waitHalted(100);
    checkOutput("final_halt_pc", {28'd0, pc}, 32'd3);
    checkOutput("final_drained", sb.size(), 0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
